// File: rtl/sram_arbiter.sv
// Two-master arbiter for a single shared SRAM port (instruction fetch vs load/store).
// One transaction in flight; data has priority, bounded by a starvation limit for fetch.
module sram_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  output logic        busy
);

  // state | meaning
  // IDLE  | no transaction; arbitrate and accept one request
  // ADDR  | mem_req high with latched fields, waiting for mem_addr_ok
  // DATA  | request accepted by memory, waiting for mem_data_ok

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          owner_data;
  logic [CW-1:0] starve_cnt;
  logic          wr_q;
  logic [3:0]    wstrb_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;

  logic          grant_data;
  logic          grant_inst;
  logic          done;

  // Grants are suppressed while reset is asserted so every output stays low in reset.
  always_comb begin
    grant_data = 1'b0;
    grant_inst = 1'b0;
    if (resetn && state == IDLE) begin
      if (data_req && (!inst_req || starve_cnt < LIMIT)) begin
        grant_data = 1'b1;
      end else if (inst_req) begin
        grant_inst = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (grant_data || grant_inst) state_nxt = ADDR;
      ADDR: if (mem_addr_ok) state_nxt = DATA;
      DATA: if (mem_data_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      owner_data <= 1'b0;
      starve_cnt <= '0;
      wr_q       <= 1'b0;
      wstrb_q    <= 4'h0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
    end else begin
      state <= state_nxt;
      if (grant_data) begin
        owner_data <= 1'b1;
        wr_q       <= data_wr;
        wstrb_q    <= data_wstrb;
        addr_q     <= data_addr;
        wdata_q    <= data_wdata;
        if (!inst_req) begin
          starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end else if (grant_inst) begin
        owner_data <= 1'b0;
        wr_q       <= 1'b0;
        wstrb_q    <= 4'h0;
        addr_q     <= inst_addr;
        wdata_q    <= 32'h0;
        starve_cnt <= '0;
      end
    end
  end

  assign done         = (state == DATA) && mem_data_ok;

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;
  assign inst_data_ok = done && !owner_data;
  assign data_data_ok = done && owner_data;
  assign inst_rdata   = inst_data_ok ? mem_rdata : 32'h0;
  assign data_rdata   = (data_data_ok && !wr_q) ? mem_rdata : 32'h0;

  assign mem_req      = (state == ADDR);
  assign mem_wr       = wr_q;
  assign mem_wstrb    = wstrb_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;

  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference model of the arbitration and handshake rules.
module tb_sram_arbiter;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  sram_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+1, outputs are checked at posedge+2.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 0;
    cyc();
    cyc();
    resetn = 1;
  endtask

  function automatic logic [138:0] obs();
    return {inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
            mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata, busy};
  endfunction

  task automatic test_reset();
    idle_inputs();
    inst_req = 1; inst_addr = 32'h1234; data_req = 1; data_wr = 1; data_wstrb = 4'hF;
    data_addr = 32'h55; data_wdata = 32'h77; mem_addr_ok = 1; mem_data_ok = 1;
    mem_rdata = 32'hFFFF_FFFF;
    resetn = 0;
    cyc(); cyc(); #1;
    n_cmp++;
    if (obs() !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got %h expected 0", obs());
    end
    resetn = 1;
    idle_inputs();
  endtask

  task automatic test_single_inst();
    do_reset();
    mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h1C00_0000;
    inst_req = 1; inst_addr = 32'h1C00_0000; #1;
    n_cmp++;
    if ({inst_addr_ok, data_addr_ok, busy, mem_req} !== 4'b1000) begin
      n_bad++; $display("FAIL single_T0: got %b expected 1000", {inst_addr_ok, data_addr_ok, busy, mem_req});
    end
    cyc(); inst_req = 0; #1;
    n_cmp++;
    if ({mem_req, mem_addr, mem_wr, mem_wstrb, busy, inst_data_ok} !== {1'b1, 32'h1C00_0000, 1'b0, 4'h0, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL single_T1: got req=%b addr=%h wr=%b strb=%h busy=%b dok=%b expected 1 1c000000 0 0 1 0",
                        mem_req, mem_addr, mem_wr, mem_wstrb, busy, inst_data_ok);
    end
    cyc(); #1;
    n_cmp++;
    if ({inst_data_ok, inst_rdata, mem_req, data_data_ok} !== {1'b1, 32'h1C00_0000, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL single_T2: got dok=%b rdata=%h req=%b ddok=%b expected 1 1c000000 0 0",
                        inst_data_ok, inst_rdata, mem_req, data_data_ok);
    end
    cyc(); #1;
    n_cmp++;
    if ({busy, inst_data_ok, inst_rdata} !== 34'h0) begin
      n_bad++; $display("FAIL single_T3: got busy=%b dok=%b rdata=%h expected 0 0 0", busy, inst_data_ok, inst_rdata);
    end
  endtask

  task automatic test_both();
    do_reset();
    mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'hAAAA_5555;
    inst_req = 1; inst_addr = 32'h2000; data_req = 1; data_wr = 0; data_addr = 32'h3000; #1;
    n_cmp++;
    if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin
      n_bad++; $display("FAIL both_T0_grant: got d=%b i=%b expected d=1 i=0", data_addr_ok, inst_addr_ok);
    end
    cyc(); data_req = 0; #1;
    n_cmp++;
    if ({mem_req, mem_addr, inst_addr_ok} !== {1'b1, 32'h3000, 1'b0}) begin
      n_bad++; $display("FAIL both_T1: got req=%b addr=%h iaok=%b expected 1 3000 0", mem_req, mem_addr, inst_addr_ok);
    end
    cyc(); #1;
    n_cmp++;
    if ({data_data_ok, data_rdata, inst_addr_ok, inst_data_ok, mem_req} !== {1'b1, 32'hAAAA_5555, 3'b000}) begin
      n_bad++; $display("FAIL both_T2: got ddok=%b rdata=%h iaok=%b idok=%b req=%b expected 1 aaaa5555 0 0 0",
                        data_data_ok, data_rdata, inst_addr_ok, inst_data_ok, mem_req);
    end
    cyc(); #1;
    n_cmp++;
    if ({inst_addr_ok, mem_req, busy} !== 3'b100) begin
      n_bad++; $display("FAIL both_T3_inst_grant: got iaok=%b req=%b busy=%b expected 1 0 0", inst_addr_ok, mem_req, busy);
    end
    cyc(); inst_req = 0; #1;
    n_cmp++;
    if ({mem_req, mem_addr, mem_wr} !== {1'b1, 32'h2000, 1'b0}) begin
      n_bad++; $display("FAIL both_T4: got req=%b addr=%h wr=%b expected 1 2000 0", mem_req, mem_addr, mem_wr);
    end
    cyc(); #1;
    n_cmp++;
    if ({inst_data_ok, inst_rdata, data_data_ok} !== {1'b1, 32'hAAAA_5555, 1'b0}) begin
      n_bad++; $display("FAIL both_T5: got idok=%b rdata=%h ddok=%b expected 1 aaaa5555 0", inst_data_ok, inst_rdata, data_data_ok);
    end
  endtask

  task automatic test_starve();
    int got = 0;
    int steps = 0;
    logic exp_data;
    do_reset();
    mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h0BAD_CAFE;
    inst_req = 1; inst_addr = 32'h10; data_req = 1; data_wr = 0; data_addr = 32'h20;
    while (got < 10 && steps < 100) begin
      #1;
      if (inst_addr_ok || data_addr_ok) begin
        exp_data = (got % (LIM + 1)) != LIM;
        n_cmp++;
        if ({inst_addr_ok, data_addr_ok} !== {!exp_data, exp_data}) begin
          n_bad++; $display("FAIL starve_order[%0d]: got i=%b d=%b expected i=%b d=%b",
                            got, inst_addr_ok, data_addr_ok, !exp_data, exp_data);
        end
        got++;
      end
      cyc();
      steps++;
    end
    n_cmp++;
    if (got != 10) begin
      n_bad++; $display("FAIL starve_timeout: got %0d grants expected 10", got);
    end
    idle_inputs();
  endtask

  task automatic test_write_wait();
    int dok = 0;
    do_reset();
    data_req = 1; data_wr = 1; data_wstrb = 4'hF; data_addr = 32'h100; data_wdata = 32'hDEAD_BEEF; #1;
    n_cmp++;
    if (data_addr_ok !== 1'b1) begin
      n_bad++; $display("FAIL write_grant: got %b expected 1", data_addr_ok);
    end
    cyc();
    data_req = 0; data_wr = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_addr_ok = 1;
      #1;
      if (data_data_ok) dok++;
      n_cmp++;
      if ({mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata, busy} !== {1'b1, 1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF, 1'b1}) begin
        n_bad++; $display("FAIL write_hold[%0d]: got req=%b wr=%b strb=%h addr=%h wdata=%h busy=%b expected 1 1 f 100 deadbeef 1",
                          i, mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata, busy);
      end
      cyc();
    end
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h1234_5678; #1;
    if (data_data_ok) dok++;
    n_cmp++;
    if ({data_data_ok, data_rdata, mem_req} !== {1'b1, 32'h0, 1'b0}) begin
      n_bad++; $display("FAIL write_done: got ddok=%b rdata=%h req=%b expected 1 0 0", data_data_ok, data_rdata, mem_req);
    end
    cyc(); #1;
    if (data_data_ok) dok++;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL write_idle: got busy=%b expected 0", busy);
    end
    cyc(); #1;
    if (data_data_ok) dok++;
    n_cmp++;
    if (dok != 1) begin
      n_bad++; $display("FAIL write_dok_count: got %0d expected 1", dok);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    inst_req = 1; inst_addr = 32'h4000; #1;
    n_cmp++;
    if (inst_addr_ok !== 1'b1) begin
      n_bad++; $display("FAIL rmid_grant: got %b expected 1", inst_addr_ok);
    end
    cyc(); inst_req = 0; mem_addr_ok = 1; #1;
    cyc(); mem_addr_ok = 0; #1;
    n_cmp++;
    if ({busy, mem_req, inst_data_ok} !== 3'b100) begin
      n_bad++; $display("FAIL rmid_in_data: got busy=%b req=%b dok=%b expected 1 0 0", busy, mem_req, inst_data_ok);
    end
    resetn = 0;
    cyc(); resetn = 1; mem_data_ok = 1; mem_rdata = 32'h5555_0000; #1;
    n_cmp++;
    if (obs() !== '0) begin
      n_bad++; $display("FAIL rmid_late_dok: got %h expected 0", obs());
    end
    cyc();
    data_req = 1; data_wr = 0; data_addr = 32'h44; mem_addr_ok = 1; mem_data_ok = 1;
    mem_rdata = 32'hCAFE_F00D; #1;
    n_cmp++;
    if (data_addr_ok !== 1'b1) begin
      n_bad++; $display("FAIL rmid_next_grant: got %b expected 1", data_addr_ok);
    end
    cyc(); data_req = 0; #1;
    n_cmp++;
    if ({mem_req, mem_addr, mem_wr} !== {1'b1, 32'h44, 1'b0}) begin
      n_bad++; $display("FAIL rmid_next_addr: got req=%b addr=%h wr=%b expected 1 44 0", mem_req, mem_addr, mem_wr);
    end
    cyc(); #1;
    n_cmp++;
    if ({data_data_ok, data_rdata} !== {1'b1, 32'hCAFE_F00D}) begin
      n_bad++; $display("FAIL rmid_next_data: got ddok=%b rdata=%h expected 1 cafef00d", data_data_ok, data_rdata);
    end
    idle_inputs();
  endtask

  task automatic test_spurious();
    do_reset();
    mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h9999_8888;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (obs() !== '0) begin
        n_bad++; $display("FAIL spur_idle[%0d]: got %h expected 0", i, obs());
      end
      cyc();
    end
    mem_addr_ok = 0; inst_req = 1; inst_addr = 32'h88; #1;
    n_cmp++;
    if (inst_addr_ok !== 1'b1) begin
      n_bad++; $display("FAIL spur_grant: got %b expected 1", inst_addr_ok);
    end
    cyc(); inst_req = 0; #1;
    n_cmp++;
    if ({mem_req, inst_data_ok, busy} !== 3'b101) begin
      n_bad++; $display("FAIL spur_addr_dok: got req=%b dok=%b busy=%b expected 1 0 1", mem_req, inst_data_ok, busy);
    end
    cyc(); mem_addr_ok = 1; #1;
    n_cmp++;
    if ({mem_req, inst_data_ok, busy} !== 3'b101) begin
      n_bad++; $display("FAIL spur_addr_accept: got req=%b dok=%b busy=%b expected 1 0 1", mem_req, inst_data_ok, busy);
    end
    cyc(); mem_addr_ok = 0; #1;
    n_cmp++;
    if ({inst_data_ok, inst_rdata, mem_req} !== {1'b1, 32'h9999_8888, 1'b0}) begin
      n_bad++; $display("FAIL spur_done: got dok=%b rdata=%h req=%b expected 1 99998888 0", inst_data_ok, inst_rdata, mem_req);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    // Reference: requester queues of depth one, one outstanding transaction,
    // and the starvation rule applied at each arbitration point.
    logic i_pend = 0, d_pend = 0;
    logic [31:0] i_a = 0, d_a = 0, d_wd = 0;
    logic d_w = 0;
    logic [3:0] d_s = 0;
    logic m_busy = 0, m_phase = 0, m_own = 0, m_wr = 0;
    logic [3:0] m_strb = 0;
    logic [31:0] m_addr = 0, m_wd = 0;
    int m_starve = 0, ni = 0, nd = 0;
    logic e_iaok, e_daok, e_idok, e_ddok, e_mreq;
    logic [31:0] e_ird, e_drd;
    logic [138:0] exp_v;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      if (!i_pend && ($urandom % 3 == 0)) begin
        i_pend = 1; i_a = $urandom;
      end
      if (!d_pend && ($urandom % 3 == 0)) begin
        d_pend = 1; d_a = $urandom; d_wd = $urandom; d_w = $urandom_range(0, 1); d_s = 4'($urandom);
      end
      inst_req = i_pend; inst_addr = i_a;
      data_req = d_pend; data_addr = d_a; data_wdata = d_wd; data_wr = d_w; data_wstrb = d_s;
      mem_addr_ok = $urandom_range(0, 1); mem_data_ok = $urandom_range(0, 1); mem_rdata = $urandom;
      #1;
      e_iaok = 0; e_daok = 0;
      if (!m_busy) begin
        if (d_pend && (!i_pend || m_starve < LIM)) e_daok = 1;
        else if (i_pend) e_iaok = 1;
      end
      e_mreq = m_busy && !m_phase;
      e_idok = m_busy && m_phase && mem_data_ok && !m_own;
      e_ddok = m_busy && m_phase && mem_data_ok && m_own;
      e_ird = e_idok ? mem_rdata : 32'h0;
      e_drd = (e_ddok && !m_wr) ? mem_rdata : 32'h0;
      exp_v = {e_iaok, e_idok, e_ird, e_daok, e_ddok, e_drd, e_mreq, m_wr, m_strb, m_addr, m_wd, m_busy};
      n_cmp++;
      if (obs() !== exp_v) begin
        n_bad++; $display("FAIL random[%0d]: got %h expected %h", c, obs(), exp_v);
      end
      if (e_daok) begin
        m_busy = 1; m_phase = 0; m_own = 1; m_wr = d_w; m_strb = d_s; m_addr = d_a; m_wd = d_wd;
        m_starve = i_pend ? ((m_starve + 1 > LIM) ? LIM : m_starve + 1) : 0;
        d_pend = 0; nd++;
      end else if (e_iaok) begin
        m_busy = 1; m_phase = 0; m_own = 0; m_wr = 0; m_strb = 0; m_addr = i_a; m_wd = 0;
        m_starve = 0; i_pend = 0; ni++;
      end else if (m_busy && !m_phase && mem_addr_ok) begin
        m_phase = 1;
      end else if (m_busy && m_phase && mem_data_ok) begin
        m_busy = 0;
      end
      cyc();
    end
    n_cmp++;
    if (ni < 10 || nd < 10) begin
      n_bad++; $display("FAIL random_progress: got inst=%0d data=%0d grants expected >=10 each", ni, nd);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_inst();
    test_both();
    test_starve();
    test_write_wait();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive data grants while inst_req is pending.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 resetn  in  1  reset, synchronous, active-low.
REQ-004 inst_req  in  1  instruction-fetch read request.
REQ-005 inst_addr  in  32  fetch address.
REQ-006 inst_addr_ok  out  1  inst request accepted and latched this cycle.
REQ-007 inst_data_ok  out  1  inst read data valid this cycle.
REQ-008 inst_rdata  out  32  fetch data.
REQ-009 data_req  in  1  load/store request.
REQ-010 data_wr  in  1  1 = write, 0 = read.
REQ-011 data_wstrb  in  4  byte write strobes.
REQ-012 data_addr  in  32  load/store address.
REQ-013 data_wdata  in  32  store data.
REQ-014 data_addr_ok  out  1  data request accepted and latched this cycle.
REQ-015 data_data_ok  out  1  data transaction complete; read data valid this cycle.
REQ-016 data_rdata  out  32  load data.
REQ-017 mem_req  out  1  shared-port request.
REQ-018 mem_wr, mem_wstrb, mem_addr, mem_wdata  out  1/4/32/32  latched transaction fields.
REQ-019 mem_addr_ok  in  1  memory accepted the request.
REQ-020 mem_data_ok  in  1  memory completed the request.
REQ-021 mem_rdata  in  32  memory read data.
REQ-022 busy  out  1  high whenever the state is not IDLE.

Function
REQ-023 The block SHALL run a 3-state FSM (IDLE, ADDR, DATA) with at most one transaction outstanding on the mem port.
REQ-024 In IDLE with any request present, the block SHALL grant exactly one requester, latch owner/addr/wr/wstrb/wdata, pulse that requester's addr_ok in the same cycle, and move to ADDR.
REQ-025 Grant rule: data wins if data_req and (!inst_req or starve_cnt < STARVE_LIMIT); otherwise inst wins. Inst grants SHALL drive wr=0 and wstrb=0.
REQ-026 starve_cnt SHALL increment (saturating at STARVE_LIMIT) on a data grant while inst_req=1, and clear on any inst grant or on a data grant with inst_req=0.
REQ-027 addr_ok SHALL never be asserted outside IDLE; a request arriving while busy SHALL wait, and its requester holds it stable.
REQ-028 In ADDR, mem_req=1 with the latched fields held stable; on mem_addr_ok the block SHALL move to DATA the next cycle.
REQ-029 In DATA, mem_req=0; on mem_data_ok the owner's data_ok SHALL be asserted combinationally that same cycle with rdata = mem_rdata, and the FSM SHALL return to IDLE.
REQ-030 Outside their data_ok cycle, inst_rdata and data_rdata SHALL be 0; the non-owner's data_ok SHALL stay 0.
REQ-031 mem_addr_ok outside ADDR and mem_data_ok outside DATA SHALL be ignored.
REQ-032 Minimum latency: req at cycle T, addr_ok at T, mem_req at T+1, data_ok at T+2 when memory responds immediately; the next grant is possible at T+3.
REQ-033 Writes SHALL complete via data_data_ok exactly like reads; data_rdata is 0 for writes.

Reset
REQ-034 With resetn=0 at a clock edge: state=IDLE, starve_cnt=0, latched fields=0, and all outputs 0 the following cycle.
REQ-035 Reset mid-transaction SHALL abort it with no data_ok issued; post-reset mem responses are ignored per REQ-031.

Verification
REQ-036 Single inst read, memory with zero wait states, mem_rdata=0x1C000000 -> inst_addr_ok at T, mem_req at T+1, inst_data_ok at T+2 with inst_rdata=0x1C000000.
REQ-037 inst_req and data_req both asserted at T -> data granted first; inst granted at T+3; no overlapping mem_req.
REQ-038 Both requesters held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-039 Data write (addr 0x100, wstrb=0xF, wdata=0xDEADBEEF), mem_addr_ok delayed 3 cycles -> mem fields stable through all 3 wait cycles; data_data_ok asserted once; data_rdata=0.
REQ-040 resetn pulled low while in DATA, then a late mem_data_ok -> no data_ok issued; busy=0; the next request is served normally.
REQ-041 Spurious mem_data_ok in IDLE -> no output change, no state change.
